// File: rtl/sr_dmem.sv
// Byte-addressed data memory with a fixed-latency request/response handshake.
// Each access takes WAIT_STATES+2 cycles from acceptance to the one-cycle valid pulse.
//
//   state  | meaning
//   IDLE   | ready high, waiting for req
//   BUSY   | access latched, wait counter running down
//   RESP   | valid pulse, rdata/err presented
module sr_dmem #(
  parameter int MEM_BYTES     = 256,
  parameter int ADDR_W        = 32,
  parameter int WAIT_STATES   = 2,
  parameter int LITTLE_ENDIAN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              valid,
  output logic [31:0]       rdata,
  output logic              err
);

  localparam int IW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              valid_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  // Contents are deliberately left unreset.
  logic [7:0]        mem_q [MEM_BYTES];

  int                nbytes;
  logic [IW-1:0]     idx  [4];
  logic [1:0]        lane [4];
  logic [ADDR_W:0]   end_addr;
  logic              acc_err;
  logic [31:0]       raw;
  logic [31:0]       ld_data;
  logic              mem_we;

  // lane[i] is the byte position within the access value of the byte at addr+i.
  always_comb begin
    case (size_q)
      2'b00:   nbytes = 1;
      2'b01:   nbytes = 2;
      default: nbytes = 4;
    endcase
    end_addr = {1'b0, addr_q} + (ADDR_W+1)'(nbytes);
    acc_err  = (size_q == 2'b11)
            || (size_q == 2'b01 && addr_q[0])
            || (size_q == 2'b10 && addr_q[1:0] != 2'b00)
            || (end_addr > (ADDR_W+1)'(MEM_BYTES));
    raw = '0;
    for (int i = 0; i < 4; i++) begin
      idx[i]  = addr_q[IW-1:0] + IW'(i);
      lane[i] = (LITTLE_ENDIAN != 0) ? 2'(i) : 2'(nbytes - 1 - i);
      if (i < nbytes) raw[{lane[i], 3'b000} +: 8] = mem_q[idx[i]];
    end
    case (size_q)
      2'b00:   ld_data = uns_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   ld_data = uns_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ld_data = raw;
    endcase
  end

  assign mem_we = (state_q == S_BUSY) && (cnt_q == 4'd0) && we_q && !acc_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (i < nbytes) mem_q[idx[i]] <= wdata_q[{lane[i], 3'b000} +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (req) begin
            we_q    <= we;
            size_q  <= size;
            uns_q   <= uns;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 4'(WAIT_STATES);
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || we_q) ? 32'd0 : ld_data;
            valid_q <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_RESP: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready = (state_q == S_IDLE);
  assign valid = valid_q;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: doc/sr_dmem.md
SR_DMEM -- requirements
Module: sr_dmem

Interface
REQ-001 SHALL provide parameter MEM_BYTES, default 256, data memory size in bytes (multiple of 4, >=4).
REQ-002 SHALL provide parameter ADDR_W, default 32, address width (>= clog2(MEM_BYTES)).
REQ-003 SHALL provide parameter WAIT_STATES, default 2, extra access cycles (0..15).
REQ-004 SHALL provide parameter LITTLE_ENDIAN, default 0; 0 = byte at lowest address is most significant of the access, 1 = least significant.
REQ-005 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req  input  1  access request.
REQ-008 SHALL have port we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-010 SHALL have port uns  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-011 SHALL have port addr  input  ADDR_W  byte address.
REQ-012 SHALL have port wdata  input  32  store data, taken from low-order bytes.
REQ-013 SHALL have port ready  output  1  block can accept a request (high only in IDLE).
REQ-014 SHALL have port valid  output  1  one-cycle response pulse.
REQ-015 SHALL have port rdata  output  32  load result, right-justified.
REQ-016 SHALL have port err  output  1  access error, qualified by valid.

Function
REQ-017 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE.
REQ-018 SHALL accept a request on a rising edge with req=1 and ready=1; latch we, size, uns, addr, wdata; load wait counter with WAIT_STATES; enter BUSY.
REQ-019 SHALL ignore req while ready=0 (no queuing); input changes after acceptance SHALL have no effect.
REQ-020 In BUSY, SHALL decrement the counter each cycle while nonzero; on the edge with counter=0, SHALL perform the access, register rdata/err, and enter RESP.
REQ-021 SHALL assert valid only in RESP, for exactly one cycle, at cycle c0+WAIT_STATES+2 where c0 is the accept cycle; RESP SHALL return to IDLE on the next edge.
REQ-022 Earliest next acceptance SHALL be at cycle c0+WAIT_STATES+3.
REQ-023 SHALL flag error if size=11, half with addr[0]!=0, word with addr[1:0]!=0, or addr+bytes > MEM_BYTES (full ADDR_W compare, no wrap); latency SHALL be unchanged.
REQ-024 On error: err=1, rdata=0, no memory write.
REQ-025 Stores SHALL write only the 1/2/4 addressed bytes; other bytes SHALL be unchanged.
REQ-026 Loads SHALL place data in rdata[8n-1:0], extending per uns; word loads ignore uns.
REQ-027 Successful accesses SHALL drive err=0; rdata SHALL be 0 for stores.
REQ-028 rdata and err SHALL hold their values until the next response.
REQ-029 Memory contents SHALL be undefined at power-up and SHALL NOT be cleared by reset.

Reset
REQ-030 On rst_n low, SHALL immediately force IDLE, counter=0, valid=0, err=0, rdata=0; ready=1.
REQ-031 Reset during BUSY SHALL abort the access: no write, no valid pulse.

Verification (MEM_BYTES=256, WAIT_STATES=2, LITTLE_ENDIAN=1 unless stated)
V1 Assert rst_n=0 mid-simulation -> valid=0, err=0, rdata=0, ready=1 without a clock edge.
V2 SW 0x10 wdata=0x8899AABB at c0, then LW 0x10 -> ready=0 in c1..c4, valid only in c4, rdata=0x8899AABB, err=0.
V3 LB 0x10 -> 0xFFFFFFBB; LBU 0x10 -> 0x000000BB; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899; LITTLE_ENDIAN=0: LB 0x10 -> 0xFFFFFF88.
V4 SB 0x11 wdata=0x12345677, then LW 0x10 -> 0x889977BB.
V5 LW 0x12, SH 0x13, size=11, SW 0xFE, LW 0x100 -> each err=1, rdata=0, valid at c0+4; SW 0xFC -> err=0; LW 0x10 still 0x889977BB.
V6 SW 0x20 wdata=0x11111111, then SW 0x20 wdata=0x22222222 with rst_n pulsed low in BUSY -> no valid; LW 0x20 -> 0x11111111.
